// File: rtl/pulse_to_level.sv
// Retriggerable one-shot: a single-cycle trigger holds level_o high for DURATION ticks.
// When the count expires naturally, the block emits a one-cycle done_o pulse.
module pulse_to_level #(
   parameter int unsigned DURATION  = 10,
   parameter int unsigned CW        = 8,
   parameter bit          RETRIGGER = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_i,
   input  logic          trig_i,
   input  logic          cancel_i,
   output logic          level_o,
   output logic          done_o,
   output logic [CW-1:0] remaining_o
);

   if (DURATION == 0 || (DURATION >> CW) != 0) begin : g_bad_duration
      $error("pulse_to_level: DURATION must lie in 1..2**CW-1");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACTIVE = 2'b01,
      S_DONE   = 2'b10
   } state_t;

   localparam logic [CW-1:0] LOAD = CW'(DURATION);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Priority inside every state: cancel > trig > tick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (!cancel_i && trig_i) begin
               state_d = S_ACTIVE;
               count_d = LOAD;
            end
         end
         S_ACTIVE: begin
            if (cancel_i) begin
               state_d = S_IDLE;
               count_d = '0;
            end else if (trig_i && RETRIGGER) begin
               count_d = LOAD;
            end else if (tick_i) begin
               if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else begin
                  state_d = S_DONE;
                  count_d = '0;
               end
            end
         end
         S_DONE: begin
            if (!cancel_i && trig_i) begin
               state_d = S_ACTIVE;
               count_d = LOAD;
            end else begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   // All outputs come from registers only, so there is no input-to-output path.
   assign level_o     = (state_q == S_ACTIVE);
   assign done_o      = (state_q == S_DONE);
   assign remaining_o = level_o ? count_q : '0;

endmodule

// File: tb/tb_pulse_to_level.sv
// Drives three one-shot variants with shared stimulus and checks them.
// Each variant is compared against a per-tick behavioural model of level, remaining and done.
module tb_pulse_to_level;

   logic clk = 1'b0;
   logic rst, tick, trig, cancel;

   logic       l0, l1, l2, d0, d1, d2;
   logic [7:0] r0, r1, r2;
   logic       lvl [3];
   logic       dn  [3];
   logic [7:0] rem [3];

   assign lvl[0] = l0;
   assign lvl[1] = l1;
   assign lvl[2] = l2;
   assign dn[0]  = d0;
   assign dn[1]  = d1;
   assign dn[2]  = d2;
   assign rem[0] = r0;
   assign rem[1] = r1;
   assign rem[2] = r2;

   // Variant 0: DURATION=3 with retrigger. Variant 1: DURATION=3 without retrigger. Variant 2: DURATION=10 with retrigger.
   pulse_to_level #(.DURATION(3), .CW(8), .RETRIGGER(1'b1)) u_d3r1 (
      .clk(clk), .rst(rst), .tick_i(tick), .trig_i(trig), .cancel_i(cancel),
      .level_o(l0), .done_o(d0), .remaining_o(r0));
   pulse_to_level #(.DURATION(3), .CW(8), .RETRIGGER(1'b0)) u_d3r0 (
      .clk(clk), .rst(rst), .tick_i(tick), .trig_i(trig), .cancel_i(cancel),
      .level_o(l1), .done_o(d1), .remaining_o(r1));
   pulse_to_level #(.DURATION(10), .CW(8), .RETRIGGER(1'b1)) u_d10r1 (
      .clk(clk), .rst(rst), .tick_i(tick), .trig_i(trig), .cancel_i(cancel),
      .level_o(l2), .done_o(d2), .remaining_o(r2));

   always #5 clk = ~clk;

   int dur [3] = '{3, 3, 10};
   bit rtg [3] = '{1'b1, 1'b0, 1'b1};
   bit exp_lvl  [3];
   bit exp_done [3];
   int exp_rem  [3];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         exp_lvl[k]  = 1'b0;
         exp_done[k] = 1'b0;
         exp_rem[k]  = 0;
      end
   endtask

   // The model tracks the outputs directly: the level stays high while ticks remain, and done marks an expiry.
   task automatic model_edge(input bit r_, input bit t_, input bit k_, input bit c_);
      bit nd;
      if (r_) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         nd = 1'b0;
         if (c_) begin
            exp_lvl[k] = 1'b0;
            exp_rem[k] = 0;
         end else if (exp_lvl[k]) begin
            if (t_ && rtg[k]) begin
               exp_rem[k] = dur[k];
            end else if (k_) begin
               if (exp_rem[k] > 1) begin
                  exp_rem[k] = exp_rem[k] - 1;
               end else begin
                  exp_lvl[k] = 1'b0;
                  exp_rem[k] = 0;
                  nd = 1'b1;
               end
            end
         end else if (t_) begin
            exp_lvl[k] = 1'b1;
            exp_rem[k] = dur[k];
         end
         exp_done[k] = nd;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.level[%0d]", tag, k), {31'd0, lvl[k]}, {31'd0, exp_lvl[k]});
         chk($sformatf("%s.done[%0d]", tag, k), {31'd0, dn[k]}, {31'd0, exp_done[k]});
         chk($sformatf("%s.remaining[%0d]", tag, k), {24'd0, rem[k]}, exp_rem[k]);
      end
   endtask

   task automatic step(input string tag, input bit r_, input bit t_, input bit k_, input bit c_);
      rst    = r_;
      trig   = t_;
      tick   = k_;
      cancel = c_;
      @(posedge clk);
      model_edge(r_, t_, k_, c_);
      #1;
      check_all(tag);
   endtask

   initial begin
      bit rr, tt, kk, cc;
      rst = 1'b1; trig = 1'b0; tick = 1'b0; cancel = 1'b0;
      model_reset();

      // Reset state, then idle with no trigger.
      step("reset", 1, 0, 0, 0);
      step("reset", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0);

      // Asynchronous reset while active with remaining=5 on the DURATION=10 variant.
      step("load10", 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step("count10", 0, 0, 1, 0);
      chk("rem_before_rst", {24'd0, r2}, 32'd5);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      step("rst_hold", 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("post_rst", 0, 0, 0, 0);

      // Basic stretch: trig at cycle 10, a tick every 4 clocks.
      for (int c = 0; c < 24; c++) begin
         step("stretch", 0, (c == 10), (c % 4 == 3), 0);
         if (c == 10) chk("stretch_rise", {24'd0, r0}, 32'd3);
         if (c == 11) chk("stretch_rem2", {24'd0, r0}, 32'd2);
         if (c == 19) chk("stretch_done", {30'd0, d0, l0}, 32'd2);
         if (c == 20) chk("stretch_idle", {30'd0, d0, l0}, 32'd0);
      end

      // Retrigger when remaining=1.
      step("clean", 0, 0, 0, 1);
      step("rt_load", 0, 1, 0, 0);
      step("rt_tick", 0, 0, 1, 0);
      step("rt_tick", 0, 0, 1, 0);
      step("rt_trig", 0, 1, 0, 0);
      chk("retrig_reload", {24'd0, r0}, 32'd3);
      for (int i = 0; i < 5; i++) step("rt_run", 0, 0, 1, 0);

      // Retrigger disabled: trig coincident with a tick at remaining=2.
      step("clean", 0, 0, 0, 1);
      step("nr_load", 0, 1, 0, 0);
      step("nr_tick", 0, 0, 1, 0);
      step("nr_trig_tick", 0, 1, 1, 0);
      chk("noretrig_rem", {24'd0, r1}, 32'd1);
      step("nr_expire", 0, 0, 1, 0);
      chk("noretrig_done", {31'd0, d1}, 32'd1);

      // Cancel together with trig while active, then trig+tick in IDLE.
      step("clean", 0, 0, 0, 1);
      step("cx_load", 0, 1, 0, 0);
      step("cx_cancel", 0, 1, 1, 1);
      chk("cancel_level", {29'd0, l0, l1, l2}, 32'd0);
      for (int i = 0; i < 3; i++) step("cx_quiet", 0, 0, 1, 0);
      step("idle_trig_tick", 0, 1, 1, 0);
      chk("idle_trig_tick_rem", {24'd0, r2}, 32'd10);

      // Expire and restart in the DONE cycle.
      step("clean", 0, 0, 0, 1);
      step("er_load", 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step("er_tick", 0, 0, 1, 0);
      chk("er_done", {31'd0, d0}, 32'd1);
      step("er_restart", 0, 1, 0, 0);
      chk("er_restart_rem", {30'd0, l0, d0}, 32'd2);

      // Back-to-back triggers hold the level indefinitely.
      for (int i = 0; i < 20; i++) step("b2b", 0, 1, ($urandom_range(0, 1) == 1), 0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rr = ($urandom_range(0, 399) == 0);
         tt = ($urandom_range(0, 7) == 0);
         kk = ($urandom_range(0, 2) == 0);
         cc = ($urandom_range(0, 39) == 0);
         step("rand", rr, tt, kk, cc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
